// File: rtl/sync_latency_meter.sv
// Round-trip latency meter: counts cycles from an accepted sync strobe to the
// first rising edge of its echo, with timeout and running min/max statistics.
module sync_latency_meter #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 echo,
    input  logic                 clr,
    output logic                 busy,
    output logic                 valid,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] lat,
    output logic [CNT_WIDTH-1:0] lat_min,
    output logic [CNT_WIDTH-1:0] lat_max
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  echo_dly_q, echo_dly_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]  lat_q, lat_d;
    logic [CNT_WIDTH-1:0]  lat_min_q, lat_min_d;
    logic [CNT_WIDTH-1:0]  lat_max_q, lat_max_d;

    logic                  echo_rise;
    logic [CNT_WIDTH-1:0]  min_base;
    logic [CNT_WIDTH-1:0]  max_base;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        echo_dly_d = echo;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        lat_d      = lat_q;

        echo_rise  = echo & ~echo_dly_q;

        // clr is applied before a same-edge sample so that sample seeds both bounds
        min_base   = clr ? '1 : lat_min_q;
        max_base   = clr ? '0 : lat_max_q;
        lat_min_d  = min_base;
        lat_max_d  = max_base;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                end
            end
            COUNT: begin
                if (echo_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    lat_d   = cnt_q;
                    if (cnt_q < min_base) begin
                        lat_min_d = cnt_q;
                    end
                    if (cnt_q > max_base) begin
                        lat_max_d = cnt_q;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            echo_dly_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            lat_q      <= '0;
            lat_min_q  <= '1;
            lat_max_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            echo_dly_q <= echo_dly_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            lat_q      <= lat_d;
            lat_min_q  <= lat_min_d;
            lat_max_q  <= lat_max_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign lat     = lat_q;
    assign lat_min = lat_min_q;
    assign lat_max = lat_max_q;

endmodule

// File: tb/tb_sync_latency_meter.sv
// Directed bench for sync_latency_meter: delay-line loopback, timeouts,
// boundary echo, pre-high echo, mid-measurement reset and clr-with-valid.
module tb_sync_latency_meter;

    logic        clk;
    logic        reset;
    logic        start;
    logic        echo;
    logic        clr;
    logic        busy;
    logic        valid;
    logic        timeout;
    logic [15:0] lat;
    logic [15:0] lat_min;
    logic [15:0] lat_max;

    int total = 0;
    int bad   = 0;

    // echo source: 0 = delay line tap, 1 = tied low, 3 = manual level
    int          mode     = 1;
    logic [4:0]  tap      = 5'd0;
    logic        echo_man = 1'b0;
    logic [31:0] dl       = '0;

    sync_latency_meter #(
        .CNT_WIDTH(16),
        .TIMEOUT  (20)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .echo   (echo),
        .clr    (clr),
        .busy   (busy),
        .valid  (valid),
        .timeout(timeout),
        .lat    (lat),
        .lat_min(lat_min),
        .lat_max(lat_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) dl <= {dl[30:0], start};

    always_comb begin
        echo = 1'b0;
        case (mode)
            0:       echo = dl[tap];
            3:       echo = echo_man;
            default: echo = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One measurement. Iteration c observes outputs of edge T+c-1 and drives
    // inputs sampled at edge T+c (T = start acceptance edge).
    task automatic measure(input string tag, input int m, input int d,
                           input int fall_at, input int rise_at, input bit xs,
                           input int clr_at, input bit exp_v, input int exp_lat,
                           input int exp_busy, input int exp_min, input int exp_max);
        int c;
        int busy_cnt;
        mode     = m;
        tap      = 5'(d - 1);
        echo_man = (fall_at > 0);
        repeat (35) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        c        = 1;
        busy_cnt = 0;
        while (c <= 100) begin
            if (m == 3) echo_man = (c < fall_at) || (rise_at != 0 && c >= rise_at);
            if (xs) start = (c == 3 || c == 10);
            clr = (c == clr_at);
            if (valid || timeout) break;
            if (busy) busy_cnt++;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        clr   = 1'b0;
        chk({tag, ".valid"},   32'(valid),   32'(exp_v));
        chk({tag, ".timeout"}, 32'(timeout), 32'(!exp_v));
        chk({tag, ".busy_lo"}, 32'(busy),    0);
        chk({tag, ".lat"},     32'(lat),     exp_lat);
        chk({tag, ".busy_n"},  busy_cnt,     exp_busy);
        @(negedge clk);
        echo_man = 1'b0;
        chk({tag, ".pulse1"},  32'(valid | timeout), 0);
        chk({tag, ".min"},     32'(lat_min), exp_min);
        chk({tag, ".max"},     32'(lat_max), exp_max);
        $display("txn %s: lat=%0d min=%0d max=%0d busy_cycles=%0d", tag, lat, lat_min, lat_max, busy_cnt);
    endtask

    initial begin
        int hits;
        reset = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy",    32'(busy),    0);
        chk("rst.valid",   32'(valid),   0);
        chk("rst.timeout", 32'(timeout), 0);
        chk("rst.lat",     32'(lat),     0);
        chk("rst.min",     32'(lat_min), 65535);
        chk("rst.max",     32'(lat_max), 0);
        reset = 1'b1;

        measure("d5",   0, 5,  0, 0, 0, 0, 1, 5,  5,  5, 5);
        measure("d1",   0, 1,  0, 0, 0, 0, 1, 1,  1,  1, 5);
        measure("d3",   0, 3,  0, 0, 0, 0, 1, 3,  3,  1, 5);
        measure("d8",   0, 8,  0, 0, 0, 0, 1, 8,  8,  1, 8);
        measure("tmo",  1, 1,  0, 0, 0, 0, 0, 8,  20, 1, 8);
        measure("d2",   0, 2,  0, 0, 0, 0, 1, 2,  2,  1, 8);
        measure("d20x", 0, 20, 0, 0, 1, 0, 1, 20, 20, 1, 20);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr.min", 32'(lat_min), 65535);
        chk("clr.max", 32'(lat_max), 0);
        $display("txn clr: min=%0d max=%0d", lat_min, lat_max);

        measure("hi_tmo",  3, 1, 100, 0, 0, 0, 0, 20, 20, 65535, 0);
        measure("hi_rise", 3, 1, 2,   7, 0, 0, 1, 7,  7,  7, 7);

        // reset while cnt = 7; the delay-line echo then arrives in IDLE
        mode = 0;
        tap  = 5'd9;
        repeat (35) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid.busy_before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("mid.busy",    32'(busy),    0);
        chk("mid.valid",   32'(valid),   0);
        chk("mid.timeout", 32'(timeout), 0);
        chk("mid.lat",     32'(lat),     0);
        chk("mid.min",     32'(lat_min), 65535);
        chk("mid.max",     32'(lat_max), 0);
        @(negedge clk);
        reset = 1'b1;
        hits  = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid || timeout || busy) hits++;
        end
        chk("mid.no_activity", hits, 0);
        $display("txn midreset: activity=%0d", hits);

        measure("d6",    0, 6, 0, 0, 0, 0, 1, 6, 6, 6, 6);
        measure("d4clr", 0, 4, 0, 0, 0, 4, 1, 4, 4, 4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
